// File: rtl/tartaruga_pkg.sv
// Shared core types.
//   bus32_t       : 32-bit address/data bus word
//   instruction_t : 32-bit raw instruction word
//   fetch_entry_t : one fetch-queue slot, {pc, instr}
package tartaruga_pkg;

  typedef logic [31:0] bus32_t;
  typedef logic [31:0] instruction_t;

  typedef struct packed {
    bus32_t       pc;
    instruction_t instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and decode.
// Captures {pc, instr} whenever fetch presents a valid instruction. Entries are
// presented in order to decode through a valid/ready handshake. When the queue
// is full, stall_o holds fetch. A taken branch (flush_i) drops every buffered
// entry and any push or pop in the same cycle.
// Ports:
//   clk_i, rstn_i               clock, asynchronous active-low reset
//   flush_i                     taken branch
//   fetch_valid_i/pc_i/instr_i  fetch side input
//   stall_o                     queue full (registered state only)
//   dec_ready_i                 decode accepts the head entry
//   dec_valid_o/pc_o/instr_o    head entry, zero when the queue is empty
//   count_o                     occupancy, 0..DEPTH
module fetch_queue
  import tartaruga_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       flush_i,
  input  logic                       fetch_valid_i,
  input  logic [31:0]                fetch_pc_i,
  input  logic [31:0]                fetch_instr_i,
  output logic                       stall_o,
  input  logic                       dec_ready_i,
  output logic                       dec_valid_o,
  output logic [31:0]                dec_pc_o,
  output logic [31:0]                dec_instr_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  fetch_entry_t    mem_q [DEPTH];
  fetch_entry_t    mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q,  count_d;

  logic            full;
  logic            not_empty;
  logic            push;
  logic            pop;
  fetch_entry_t    head;

  assign full      = (count_q == CW'(DEPTH));
  assign not_empty = (count_q != '0);

  // Full refuses a push even when a pop happens in the same cycle; fetch is
  // stalled and re-presents the instruction next cycle, so nothing is lost.
  assign push = fetch_valid_i & ~full & ~flush_i;
  assign pop  = not_empty & dec_ready_i & ~flush_i;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = '{pc: fetch_pc_i, instr: fetch_instr_i};
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    head = not_empty ? mem_q[rd_ptr_q] : '0;
  end

  assign stall_o     = full;
  assign dec_valid_o = not_empty;
  assign dec_pc_o    = head.pc;
  assign dec_instr_o = head.instr;
  assign count_o     = count_q;

endmodule
